// File: rtl/result_packer.sv
// Result FIFO write-side packer: stamps ADC/AUX events, emits 64-bit data and epoch records.
// Optional RESULT_PACKER_DROP_REC_EN adds a tag-E drop-count record.
`timescale 1ns/1ps
module result_packer #(
  parameter int TS_W   = 48,
  parameter int LO_W   = 28,
  parameter int DROP_W = 16
) (
  input  logic              fpga_clk_i,
  input  logic              reset_n_i,
  input  logic [TS_W-1:0]   clock_i,
  input  logic              adc_valid_i,
  input  logic [31:0]       adc_data_i,
  input  logic              aux_valid_i,
  input  logic [15:0]       aux_data_i,
  input  logic              fifo_full_i,
  output logic              fifo_wr_o,
  output logic [63:0]       fifo_data_o,
  output logic              idle_o,
  output logic [DROP_W-1:0] drop_count_o,
  output logic [1:0]        dbg_state_o
);
  // Write side: fifo_wr_o pulses one cycle per record and is only raised when
  // fifo_full_i was low at the edge that registers it; fifo_data_o is stable while high.
  localparam int EP_W = TS_W - LO_W;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EPOCH = 2'd1, S_DATA = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              adc_full_q, adc_full_d, aux_full_q, aux_full_d;
  logic [31:0]       adc_data_q, adc_data_d;
  logic [15:0]       aux_data_q, aux_data_d;
  logic [TS_W-1:0]   adc_ts_q, adc_ts_d, aux_ts_q, aux_ts_d;
  logic              sel_adc_q, sel_adc_d;
  logic [EP_W-1:0]   last_epoch_q, last_epoch_d;
  logic              epoch_valid_q, epoch_valid_d;
  logic              wr_q, wr_d;
  logic [63:0]       data_q, data_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              pop_adc, pop_aux, adc_drop, aux_drop;
  logic              any_full;
  logic [TS_W-1:0]   cand_ts, sel_ts;
  logic [EP_W-1:0]   cand_epoch, sel_epoch;
  logic [DROP_W:0]   drop_sum;
`ifdef RESULT_PACKER_DROP_REC_EN
  logic              drops_pending_q, drops_pending_d, drop_rec_clr;
`endif

  assign any_full   = adc_full_q | aux_full_q;
  assign cand_ts    = adc_full_q ? adc_ts_q : aux_ts_q;
  assign cand_epoch = cand_ts[TS_W-1:LO_W];
  assign sel_ts     = sel_adc_q ? adc_ts_q : aux_ts_q;
  assign sel_epoch  = sel_ts[TS_W-1:LO_W];

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_full)
                 state_d = (!epoch_valid_q || cand_epoch != last_epoch_q) ? S_EPOCH : S_DATA;
      S_EPOCH: if (!fifo_full_i) state_d = S_DATA;
      S_DATA:  if (!fifo_full_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_d          = 1'b0;
    data_d        = data_q;
    sel_adc_d     = sel_adc_q;
    last_epoch_d  = last_epoch_q;
    epoch_valid_d = epoch_valid_q;
    pop_adc       = 1'b0;
    pop_aux       = 1'b0;
`ifdef RESULT_PACKER_DROP_REC_EN
    drop_rec_clr  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_full) begin
          sel_adc_d = adc_full_q;
`ifdef RESULT_PACKER_DROP_REC_EN
        end else if (drops_pending_q && !fifo_full_i) begin
          wr_d         = 1'b1;
          data_d       = {4'hE, {(60-DROP_W){1'b0}}, drop_q};
          drop_rec_clr = 1'b1;
`endif
        end
      end
      S_EPOCH: if (!fifo_full_i) begin
        wr_d          = 1'b1;
        data_d        = {4'hF, 12'h000, {(48-EP_W){1'b0}}, sel_epoch};
        last_epoch_d  = sel_epoch;
        epoch_valid_d = 1'b1;
      end
      S_DATA: if (!fifo_full_i) begin
        wr_d    = 1'b1;
        data_d  = sel_adc_q ? {4'h1, sel_ts[LO_W-1:0], adc_data_q}
                            : {4'h2, sel_ts[LO_W-1:0], 16'h0000, aux_data_q};
        pop_adc = sel_adc_q;
        pop_aux = !sel_adc_q;
      end
      default: ;
    endcase
  end

  // A strobe arriving while its register is popped refills it rather than dropping.
  always_comb begin
    adc_full_d = adc_full_q & ~pop_adc;
    adc_data_d = adc_data_q;
    adc_ts_d   = adc_ts_q;
    adc_drop   = 1'b0;
    aux_full_d = aux_full_q & ~pop_aux;
    aux_data_d = aux_data_q;
    aux_ts_d   = aux_ts_q;
    aux_drop   = 1'b0;
    if (adc_valid_i) begin
      if (!adc_full_q || pop_adc) begin
        adc_full_d = 1'b1;
        adc_data_d = adc_data_i;
        adc_ts_d   = clock_i;
      end else begin
        adc_drop = 1'b1;
      end
    end
    if (aux_valid_i) begin
      if (!aux_full_q || pop_aux) begin
        aux_full_d = 1'b1;
        aux_data_d = aux_data_i;
        aux_ts_d   = clock_i;
      end else begin
        aux_drop = 1'b1;
      end
    end
    drop_sum = {1'b0, drop_q} + (DROP_W+1)'(adc_drop) + (DROP_W+1)'(aux_drop);
    drop_d   = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
  end

`ifdef RESULT_PACKER_DROP_REC_EN
  assign drops_pending_d = (drops_pending_q & ~drop_rec_clr) | adc_drop | aux_drop;

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) drops_pending_q <= 1'b0;
    else            drops_pending_q <= drops_pending_d;
  end
`endif

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      adc_full_q    <= 1'b0;
      adc_data_q    <= '0;
      adc_ts_q      <= '0;
      aux_full_q    <= 1'b0;
      aux_data_q    <= '0;
      aux_ts_q      <= '0;
      sel_adc_q     <= 1'b0;
      last_epoch_q  <= '0;
      epoch_valid_q <= 1'b0;
      wr_q          <= 1'b0;
      data_q        <= '0;
      drop_q        <= '0;
    end else begin
      adc_full_q    <= adc_full_d;
      adc_data_q    <= adc_data_d;
      adc_ts_q      <= adc_ts_d;
      aux_full_q    <= aux_full_d;
      aux_data_q    <= aux_data_d;
      aux_ts_q      <= aux_ts_d;
      sel_adc_q     <= sel_adc_d;
      last_epoch_q  <= last_epoch_d;
      epoch_valid_q <= epoch_valid_d;
      wr_q          <= wr_d;
      data_q        <= data_d;
      drop_q        <= drop_d;
    end
  end

  assign fifo_wr_o    = wr_q;
  assign fifo_data_o  = data_q;
  assign drop_count_o = drop_q;
  assign idle_o       = (state_q == S_IDLE) && !any_full;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_result_packer.sv
// Self-checking bench for result_packer: directed scenarios plus randomized slots
// checked against a record-stream reference model.
`timescale 1ns/1ps
module tb_result_packer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] clock_i = '0;
  logic        adc_valid_i = 1'b0;
  logic [31:0] adc_data_i = '0;
  logic        aux_valid_i = 1'b0;
  logic [15:0] aux_data_i = '0;
  logic        fifo_full_i = 1'b0;
  logic        fifo_wr_o;
  logic [63:0] fifo_data_o;
  logic        idle_o;
  logic [15:0] drop_count_o;
  logic [1:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [19:0] m_last_epoch = '0;
  bit          m_epoch_valid = 1'b0;
  logic        full_at_edge = 1'b0;

  result_packer dut (
    .fpga_clk_i(clk), .reset_n_i(rst_n), .clock_i(clock_i),
    .adc_valid_i(adc_valid_i), .adc_data_i(adc_data_i),
    .aux_valid_i(aux_valid_i), .aux_data_i(aux_data_i),
    .fifo_full_i(fifo_full_i), .fifo_wr_o(fifo_wr_o), .fifo_data_o(fifo_data_o),
    .idle_o(idle_o), .drop_count_o(drop_count_o), .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: every accepted event yields an optional epoch record then its data record.
  task model_event(input bit is_adc, input logic [31:0] d, input logic [47:0] ts);
    logic [19:0] ep;
    ep = ts[47:28];
    if (!m_epoch_valid || ep != m_last_epoch) begin
      exp_q.push_back({4'hF, 12'h000, 28'h0, ep});
      m_last_epoch  = ep;
      m_epoch_valid = 1'b1;
    end
    if (is_adc) exp_q.push_back({4'h1, ts[27:0], d});
    else        exp_q.push_back({4'h2, ts[27:0], 16'h0000, d[15:0]});
  endtask

  // Scoreboard
  always @(posedge clk) full_at_edge <= fifo_full_i;

  always @(negedge clk) begin
    if (rst_n && fifo_wr_o) begin
      logic [63:0] exp;
      checks++;
      if (full_at_edge) begin
        errors++;
        $display("FAIL wr_while_full: fifo_wr_o=1 data=%h but fifo_full_i was 1", fifo_data_o);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record: got %h, expected no write", fifo_data_o);
      end else begin
        exp = exp_q.pop_front();
        if (fifo_data_o !== exp) begin
          errors++;
          $display("FAIL record: got %h expected %h", fifo_data_o, exp);
        end
      end
    end
  end

  task next_cycle();
    @(negedge clk);
    clock_i     = clock_i + 48'd1;
    adc_valid_i = 1'b0;
    aux_valid_i = 1'b0;
  endtask

  task drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !idle_o) && n < 300) begin
      next_cycle();
      n++;
    end
    repeat (4) next_cycle();
    checks++;
    if (exp_q.size() != 0 || !idle_o) begin
      errors++;
      $display("FAIL drain_%s: %0d records outstanding, idle_o=%b, required 0 and 1",
               name, exp_q.size(), idle_o);
    end
  endtask

  task test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (fifo_wr_o !== 1'b0 || fifo_data_o !== 64'h0 || idle_o !== 1'b1 ||
        drop_count_o !== 16'h0 || dbg_state_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: wr=%b data=%h idle=%b drop=%h state=%0d, required 0/0/1/0/0",
               fifo_wr_o, fifo_data_o, idle_o, drop_count_o, dbg_state_o);
    end
    rst_n = 1'b1;
  endtask

  task test_first_epoch();
    logic [6:1]  pat;
    logic [63:0] rec3, rec4;
    pat = '0; rec3 = '0; rec4 = '0;
    next_cycle();
    clock_i = 48'h0000_1234_5678;
    adc_valid_i = 1'b1; adc_data_i = 32'hDEAD_BEEF;
    model_event(1'b1, adc_data_i, clock_i);
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      pat[k] = fifo_wr_o;
      if (k == 3) rec3 = fifo_data_o;
      if (k == 4) rec4 = fifo_data_o;
    end
    checks++;
    if (pat !== 6'b001100) begin
      errors++;
      $display("FAIL first_latency: write pattern %b, required 001100", pat);
    end
    checks++;
    if (rec3 !== 64'hF000_0000_0000_0001) begin
      errors++;
      $display("FAIL first_epoch_rec: got %h required %h", rec3, 64'hF000_0000_0000_0001);
    end
    checks++;
    if (rec4 !== {4'h1, 28'h234_5678, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL first_data_rec: got %h required %h", rec4, {4'h1, 28'h234_5678, 32'hDEAD_BEEF});
    end
    drain("first");
  endtask

  task test_same_epoch();
    logic [6:1] pat;
    pat = '0;
    next_cycle();
    adc_valid_i = 1'b1; adc_data_i = 32'h0BAD_F00D;
    model_event(1'b1, adc_data_i, clock_i);
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      pat[k] = fifo_wr_o;
    end
    checks++;
    if (pat !== 6'b000100) begin
      errors++;
      $display("FAIL same_epoch_latency: write pattern %b, required 000100", pat);
    end
    drain("same_epoch");
  endtask

  task test_dual();
    logic [6:1] pat;
    pat = '0;
    next_cycle();
    adc_valid_i = 1'b1; adc_data_i = $urandom;
    aux_valid_i = 1'b1; aux_data_i = 16'(($urandom));
    model_event(1'b1, adc_data_i, clock_i);
    model_event(1'b0, {16'h0, aux_data_i}, clock_i);
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      pat[k] = fifo_wr_o;
    end
    checks++;
    if (pat !== 6'b010100) begin
      errors++;
      $display("FAIL dual_order: write pattern %b, required 010100", pat);
    end
    drain("dual");
  endtask

  task test_full();
    int wr_full;
    logic [15:0] drop0;
    wr_full = 0;
    drop0 = drop_count_o;
    next_cycle();
    fifo_full_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c != 0) next_cycle();
      if (fifo_wr_o) wr_full++;
      if (c % 6 == 0 && c < 18) begin
        adc_valid_i = 1'b1; adc_data_i = $urandom;
        if (c == 0) model_event(1'b1, adc_data_i, clock_i);
      end
    end
    next_cycle();
    if (fifo_wr_o) wr_full++;
    checks++;
    if (wr_full != 0) begin
      errors++;
      $display("FAIL full_no_write: %0d writes during full, required 0", wr_full);
    end
    checks++;
    if (drop_count_o !== drop0 + 16'd2) begin
      errors++;
      $display("FAIL full_drop_count: got %0d required %0d", drop_count_o, drop0 + 16'd2);
    end
    fifo_full_i = 1'b0;
`ifdef RESULT_PACKER_DROP_REC_EN
    exp_q.push_back({4'hE, 44'h0, drop0 + 16'd2});
`endif
    drain("full");
  endtask

  task test_epoch_wrap();
    logic [63:0] last_ep;
    last_ep = '0;
    next_cycle();
    clock_i = {20'h00005, 28'hFFF_FFF8};
    aux_valid_i = 1'b1; aux_data_i = 16'hA5A5;
    model_event(1'b0, {16'h0, aux_data_i}, clock_i);
    for (int k = 0; k < 12; k++) begin
      next_cycle();
      if (fifo_wr_o && fifo_data_o[63:60] == 4'hF) last_ep = fifo_data_o;
    end
    aux_valid_i = 1'b1; aux_data_i = 16'h5A5A;
    model_event(1'b0, {16'h0, aux_data_i}, clock_i);
    for (int k = 0; k < 12; k++) begin
      next_cycle();
      if (fifo_wr_o && fifo_data_o[63:60] == 4'hF) last_ep = fifo_data_o;
    end
    checks++;
    if (last_ep !== 64'hF000_0000_0000_0006) begin
      errors++;
      $display("FAIL wrap_epoch: last epoch record %h required %h", last_ep, 64'hF000_0000_0000_0006);
    end
    drain("wrap");
  endtask

  task test_back_to_back();
    logic [15:0] drop0;
    next_cycle();
    clock_i = 48'h0000_2000_0000;
    adc_valid_i = 1'b1; adc_data_i = $urandom;
    model_event(1'b1, adc_data_i, clock_i);
    drain("b2b_warm");
    drop0 = drop_count_o;
    for (int c = 0; c < 16; c++) begin
      next_cycle();
      if (c % 2 == 0) begin
        adc_valid_i = 1'b1; adc_data_i = $urandom;
        model_event(1'b1, adc_data_i, clock_i);
      end
    end
    drain("b2b");
    checks++;
    if (drop_count_o !== drop0) begin
      errors++;
      $display("FAIL b2b_no_drop: drop_count %0d required %0d", drop_count_o, drop0);
    end
  endtask

  task test_random();
    int kind;
    for (int s = 0; s < 30; s++) begin
      next_cycle();
      if ($urandom_range(0, 3) == 0) clock_i = {16'($urandom), $urandom};
      kind = $urandom_range(0, 2);
      if (kind != 1) begin
        adc_valid_i = 1'b1; adc_data_i = $urandom;
        model_event(1'b1, adc_data_i, clock_i);
      end
      if (kind != 0) begin
        aux_valid_i = 1'b1; aux_data_i = 16'($urandom);
        model_event(1'b0, {16'h0, aux_data_i}, clock_i);
      end
      repeat (11) next_cycle();
    end
    drain("random");
  endtask

  task test_reset_mid();
    next_cycle();
    clock_i = 48'h0000_7000_0010;
    adc_valid_i = 1'b1; adc_data_i = 32'h1234_5678;
    model_event(1'b1, adc_data_i, clock_i);
    repeat (3) next_cycle();
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    m_epoch_valid = 1'b0;
    m_last_epoch  = '0;
    #1;
    checks++;
    if (fifo_wr_o !== 1'b0 || idle_o !== 1'b1 || drop_count_o !== 16'h0 || dbg_state_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: wr=%b idle=%b drop=%0d state=%0d, required 0/1/0/0",
               fifo_wr_o, idle_o, drop_count_o, dbg_state_o);
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    adc_valid_i = 1'b1; adc_data_i = 32'hCAFE_0001;
    model_event(1'b1, adc_data_i, clock_i);
    drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_first_epoch();
    test_same_epoch();
    test_dual();
    test_full();
    test_epoch_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
